// File: rtl/hdmi_rx_decode.sv
// hdmi_rx_decode: TMDS word alignment, period tracking and
// video / TERC4 / control-token decode for an HDMI or DVI sink.
module hdmi_rx_decode #(
    parameter string MODE          = "HDMI",
    parameter int    SEARCH_WINDOW = 4096,
    parameter int    PREAMBLE_MIN  = 8
) (
    input  logic       pix_clk,
    input  logic       rst_n,
    input  logic [9:0] tmds_b,
    input  logic [9:0] tmds_g,
    input  logic [9:0] tmds_r,
    output logic [2:0] bitslip,
    output logic       aligned,
    output logic [7:0] blue,
    output logic [7:0] green,
    output logic [7:0] red,
    output logic       hsync,
    output logic       vsync,
    output logic       vde,
    output logic [3:0] aux0,
    output logic [3:0] aux1,
    output logic [3:0] aux2,
    output logic       ade,
    output logic       err
);

    localparam bit         IS_DVI = (MODE == "DVI");
    localparam int         SW_W   = $clog2(SEARCH_WINDOW);
    localparam logic [7:0] PMIN   = 8'(PREAMBLE_MIN);
    localparam logic [9:0] CTL0   = 10'b1101010100;
    localparam logic [9:0] CTL1   = 10'b0010101011;
    localparam logic [9:0] CTL2   = 10'b0101010100;
    localparam logic [9:0] CTL3   = 10'b1010101011;
    localparam logic [9:0] GB     = 10'b0100110011;

    typedef enum logic [2:0] {
        CTRL, VGB, VIDEO, DGB_L, ISLAND, DGB_T
    } period_t;

    function automatic logic is_ctl(input logic [9:0] s);
        return (s == CTL0) || (s == CTL1) || (s == CTL2) || (s == CTL3);
    endfunction

    function automatic logic [1:0] ctl_val(input logic [9:0] s);
        logic [1:0] v;
        case (s)
            CTL1:    v = 2'b01;
            CTL2:    v = 2'b10;
            CTL3:    v = 2'b11;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    // Returns {valid, code}.
    function automatic logic [4:0] terc4(input logic [9:0] s);
        logic [4:0] v;
        case (s)
            10'b1010011100: v = 5'h10;
            10'b1001100011: v = 5'h11;
            10'b1011100100: v = 5'h12;
            10'b1011100010: v = 5'h13;
            10'b0101110001: v = 5'h14;
            10'b0100011110: v = 5'h15;
            10'b0110001110: v = 5'h16;
            10'b0100111100: v = 5'h17;
            10'b1011001100: v = 5'h18;
            10'b0100111001: v = 5'h19;
            10'b0110011100: v = 5'h1a;
            10'b1011000110: v = 5'h1b;
            10'b1010001110: v = 5'h1c;
            10'b1001110001: v = 5'h1d;
            10'b0101100011: v = 5'h1e;
            10'b1011000011: v = 5'h1f;
            default:        v = 5'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] vdec(input logic [9:0] s);
        logic [7:0] b;
        logic [7:0] d;
        b      = s[9] ? ~s[7:0] : s[7:0];
        d[0]   = b[0];
        d[7:1] = s[8] ? (b[7:1] ^ b[6:0]) : ~(b[7:1] ^ b[6:0]);
        return d;
    endfunction

    // Async assert, pix_clk-synchronous release.
    logic [1:0] rst_sync;
    logic       rst_s;

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_s = rst_sync[1];

    logic [9:0] sym [3];
    logic [2:0] lock;

    assign sym[0] = tmds_b;
    assign sym[1] = tmds_g;
    assign sym[2] = tmds_r;

    for (genvar i = 0; i < 3; i++) begin : g_align
        logic [SW_W-1:0] srch;
        logic [1:0]      hold;
        logic [3:0]      run;
        logic            lk;
        logic            bs;

        always_ff @(posedge pix_clk or negedge rst_s) begin
            if (!rst_s) begin
                srch <= '0;
                hold <= 2'd0;
                run  <= 4'd0;
                lk   <= 1'b0;
                bs   <= 1'b0;
            end else begin
                bs <= 1'b0;
                if (hold != 2'd0) begin
                    hold <= hold - 2'd1;
                end else if (is_ctl(sym[i])) begin
                    srch <= '0;
                    if (run == 4'd11) lk  <= 1'b1;
                    else              run <= run + 4'd1;
                end else if (srch == SW_W'(SEARCH_WINDOW - 1)) begin
                    bs   <= 1'b1;
                    srch <= '0;
                    hold <= 2'd3;
                    run  <= 4'd0;
                    lk   <= 1'b0;
                end else begin
                    srch <= srch + SW_W'(1);
                    run  <= 4'd0;
                end
            end
        end

        assign lock[i]    = lk;
        assign bitslip[i] = bs;
    end

    always_ff @(posedge pix_clk or negedge rst_s) begin
        if (!rst_s) aligned <= 1'b0;
        else        aligned <= &lock;
    end

    logic       b_ctl, g_ctl, r_ctl;
    logic [1:0] g_cv, r_cv;
    logic [4:0] b_t4, g_t4, r_t4;

    assign b_ctl = is_ctl(tmds_b);
    assign g_ctl = is_ctl(tmds_g);
    assign r_ctl = is_ctl(tmds_r);
    assign g_cv  = ctl_val(tmds_g);
    assign r_cv  = ctl_val(tmds_r);
    assign b_t4  = terc4(tmds_b);
    assign g_t4  = terc4(tmds_g);
    assign r_t4  = terc4(tmds_r);

    // state is the period of the symbol now held in s1_*.
    period_t    state, state_n;
    logic       gcnt, gcnt_n;
    logic [7:0] pcnt, pcnt_n;
    logic       pisl, pisl_n;
    logic       bad, err_q;
    logic       pre_ok;

    assign pre_ok = g_ctl && (g_cv == 2'b01) && r_ctl && !r_cv[1];

    always_ff @(posedge pix_clk or negedge rst_s) begin
        if (!rst_s) begin
            state <= CTRL;
            gcnt  <= 1'b0;
            pcnt  <= 8'd0;
            pisl  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            gcnt  <= gcnt_n;
            pcnt  <= pcnt_n;
            pisl  <= pisl_n;
            err_q <= bad;
        end
    end

    always_comb begin
        state_n = state;
        gcnt_n  = 1'b0;
        pcnt_n  = 8'd0;
        pisl_n  = pisl;
        bad     = 1'b0;
        case (state)
            CTRL: begin
                if (pre_ok) begin
                    pisl_n = r_cv[0];
                    if (r_cv[0] != pisl) pcnt_n = 8'd1;
                    else if (pcnt == 8'hff) pcnt_n = pcnt;
                    else pcnt_n = pcnt + 8'd1;
                end
                if (tmds_g == GB && pcnt >= PMIN)
                    state_n = pisl ? DGB_L : VGB;
                else if (!g_ctl)
                    bad = 1'b1;
            end
            VGB: begin
                if (gcnt) state_n = VIDEO;
                else      gcnt_n  = 1'b1;
            end
            VIDEO: begin
                if (b_ctl) state_n = CTRL;
            end
            DGB_L: begin
                if (gcnt) state_n = ISLAND;
                else      gcnt_n  = 1'b1;
            end
            ISLAND: begin
                if (tmds_g == GB && tmds_r == GB) begin
                    state_n = DGB_T;
                end else if (!(b_t4[4] && g_t4[4] && r_t4[4])) begin
                    bad     = 1'b1;
                    state_n = CTRL;
                end
            end
            DGB_T: begin
                if (gcnt) state_n = CTRL;
                else      gcnt_n  = 1'b1;
            end
            default: state_n = CTRL;
        endcase
        if (IS_DVI || !aligned) begin
            state_n = CTRL;
            gcnt_n  = 1'b0;
            pcnt_n  = 8'd0;
            bad     = 1'b0;
        end
    end

    logic [9:0] s1_b, s1_g, s1_r;

    always_ff @(posedge pix_clk or negedge rst_s) begin
        if (!rst_s) begin
            s1_b <= 10'd0;
            s1_g <= 10'd0;
            s1_r <= 10'd0;
        end else begin
            s1_b <= tmds_b;
            s1_g <= tmds_g;
            s1_r <= tmds_r;
        end
    end

    logic       vde_n, ade_n, hs_n, vs_n;
    logic [7:0] blue_n, green_n, red_n;
    logic [3:0] aux0_n, aux1_n, aux2_n;
    logic [4:0] s1b_t4, s1g_t4, s1r_t4;
    logic [1:0] s1b_cv;
    logic       s1b_ctl;

    assign s1b_ctl = is_ctl(s1_b);
    assign s1b_cv  = ctl_val(s1_b);
    assign s1b_t4  = terc4(s1_b);
    assign s1g_t4  = terc4(s1_g);
    assign s1r_t4  = terc4(s1_r);

    always_comb begin
        vde_n   = IS_DVI ? (aligned && !s1b_ctl) : (state == VIDEO);
        ade_n   = !IS_DVI && (state == ISLAND);
        hs_n    = hsync;
        vs_n    = vsync;
        blue_n  = 8'd0;
        green_n = 8'd0;
        red_n   = 8'd0;
        aux0_n  = 4'd0;
        aux1_n  = 4'd0;
        aux2_n  = 4'd0;
        if (vde_n) begin
            blue_n  = vdec(s1_b);
            green_n = vdec(s1_g);
            red_n   = vdec(s1_r);
        end
        if (ade_n) begin
            aux0_n = s1b_t4[3:0];
            aux1_n = s1g_t4[3:0];
            aux2_n = s1r_t4[3:0];
            hs_n   = s1b_t4[0];
            vs_n   = s1b_t4[1];
        end else if (state == CTRL && s1b_ctl) begin
            hs_n = s1b_cv[0];
            vs_n = s1b_cv[1];
        end
    end

    always_ff @(posedge pix_clk or negedge rst_s) begin
        if (!rst_s) begin
            vde   <= 1'b0;
            ade   <= 1'b0;
            err   <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            blue  <= 8'd0;
            green <= 8'd0;
            red   <= 8'd0;
            aux0  <= 4'd0;
            aux1  <= 4'd0;
            aux2  <= 4'd0;
        end else begin
            vde   <= vde_n;
            ade   <= ade_n;
            err   <= err_q;
            hsync <= hs_n;
            vsync <= vs_n;
            blue  <= blue_n;
            green <= green_n;
            red   <= red_n;
            aux0  <= aux0_n;
            aux1  <= aux1_n;
            aux2  <= aux2_n;
        end
    end

endmodule

// File: tb/tb_hdmi_rx_decode.sv
// tb_hdmi_rx_decode: random HDMI period sequences checked against
// an encoder-based reference with a two-cycle output pipeline.
module tb_hdmi_rx_decode;

    localparam int K_SKIP = 0;
    localparam int K_CTRL = 1;
    localparam int K_GB   = 2;
    localparam int K_VID  = 3;
    localparam int K_ISL  = 4;
    localparam int K_ERR  = 5;
    localparam int PMIN   = 8;

    localparam logic [9:0] GB  = 10'b0100110011;
    localparam logic [9:0] VGB = 10'b1011001100;

    logic       pix_clk = 1'b0;
    logic       rst_n;
    logic [9:0] tmds_b, tmds_g, tmds_r;
    logic [2:0] bitslip;
    logic       aligned, hsync, vsync, vde, ade, err;
    logic [7:0] blue, green, red;
    logic [3:0] aux0, aux1, aux2;

    hdmi_rx_decode dut (
        .pix_clk (pix_clk),
        .rst_n   (rst_n),
        .tmds_b  (tmds_b),
        .tmds_g  (tmds_g),
        .tmds_r  (tmds_r),
        .bitslip (bitslip),
        .aligned (aligned),
        .blue    (blue),
        .green   (green),
        .red     (red),
        .hsync   (hsync),
        .vsync   (vsync),
        .vde     (vde),
        .aux0    (aux0),
        .aux1    (aux1),
        .aux2    (aux2),
        .ade     (ade),
        .err     (err)
    );

    always #5 pix_clk = ~pix_clk;

    logic [9:0] CTL [4] = '{10'b1101010100, 10'b0010101011,
                            10'b0101010100, 10'b1010101011};
    logic [9:0] T4 [16] = '{10'b1010011100, 10'b1001100011,
                            10'b1011100100, 10'b1011100010,
                            10'b0101110001, 10'b0100011110,
                            10'b0110001110, 10'b0100111100,
                            10'b1011001100, 10'b0100111001,
                            10'b0110011100, 10'b1011000110,
                            10'b1010001110, 10'b1001110001,
                            10'b0101100011, 10'b1011000011};

    typedef struct {
        bit         on;
        bit         vde, ade, err, hs, vs;
        logic [7:0] b, g, r;
        logic [3:0] a0, a1, a2;
    } exp_t;

    int   n_chk = 0;
    int   n_err = 0;
    bit   m_hs = 1'b0;
    bit   m_vs = 1'b0;
    exp_t prev = '{default: 0};

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int tok_idx(input logic [9:0] s);
        for (int k = 0; k < 4; k++)
            if (CTL[k] == s) return k;
        return -1;
    endfunction

    // Forward TMDS encoder (stage 1 + optional inversion).
    function automatic logic [9:0] enc(input logic [7:0] d,
                                       input bit x, input bit inv);
        logic [7:0] q;
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = x ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
        return {inv, x, inv ? ~q : q};
    endfunction

    task automatic step(input int kind,
                        input logic [9:0] b, g, r,
                        input logic [7:0] eb, eg, er,
                        input logic [3:0] ab, ag, ar);
        exp_t e;
        int   k;
        e    = '{default: 0};
        e.on = (kind != K_SKIP);
        case (kind)
            K_SKIP, K_CTRL: begin
                k = tok_idx(b);
                if (k >= 0) begin
                    m_hs = k[0];
                    m_vs = k[1];
                end
            end
            K_VID: begin
                e.vde = 1'b1;
                e.b = eb; e.g = eg; e.r = er;
            end
            K_ISL: begin
                e.ade = 1'b1;
                e.a0 = ab; e.a1 = ag; e.a2 = ar;
                m_hs = ab[0];
                m_vs = ab[1];
            end
            K_ERR: e.err = 1'b1;
            default: ;
        endcase
        e.hs = m_hs;
        e.vs = m_vs;
        tmds_b = b;
        tmds_g = g;
        tmds_r = r;
        @(posedge pix_clk);
        @(negedge pix_clk);
        if (prev.on) begin
            check("vde", 64'(vde), 64'(prev.vde));
            check("ade", 64'(ade), 64'(prev.ade));
            check("err", 64'(err), 64'(prev.err));
            check("sync", 64'({hsync, vsync}), 64'({prev.hs, prev.vs}));
            check("video", 64'({blue, green, red}),
                  64'({prev.b, prev.g, prev.r}));
            check("aux", 64'({aux0, aux1, aux2}),
                  64'({prev.a0, prev.a1, prev.a2}));
            check("link", 64'({aligned, bitslip}), 64'(4'b1000));
        end
        prev = e;
    endtask

    task automatic ctrl_cycles(input int n);
        for (int i = 0; i < n; i++)
            step(K_CTRL, CTL[$urandom_range(0, 3)], CTL[0], CTL[0],
                 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preamble(input int n, input bit isl);
        for (int i = 0; i < n; i++)
            step(K_CTRL, CTL[$urandom_range(0, 3)], CTL[1],
                 isl ? CTL[1] : CTL[0], 0, 0, 0, 0, 0, 0);
    endtask

    task automatic vguard();
        for (int i = 0; i < 2; i++)
            step(K_GB, VGB, GB, VGB, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pixel(input bit fix, input logic [9:0] fw,
                         input logic [7:0] fd);
        logic [7:0] d [3];
        logic [9:0] w [3];
        for (int c = 0; c < 3; c++) begin
            do begin
                d[c] = 8'($urandom);
                w[c] = enc(d[c], 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
            end while (tok_idx(w[c]) >= 0);
        end
        if (fix) begin
            w[0] = fw;
            d[0] = fd;
        end
        step(K_VID, w[0], w[1], w[2], d[0], d[1], d[2], 0, 0, 0);
    endtask

    task automatic island(input int n, input bit bad);
        logic [3:0] ab, ag, ar;
        preamble(PMIN + $urandom_range(0, 3), 1'b1);
        for (int i = 0; i < 2; i++)
            step(K_GB, T4[$urandom_range(0, 15)], GB, GB,
                 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            ab = 4'($urandom_range(0, 15));
            ag = (i == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            ar = 4'($urandom_range(0, 15));
            step(K_ISL, T4[ab], T4[ag], T4[ar], 0, 0, 0, ab, ag, ar);
        end
        if (bad) begin
            step(K_ERR, T4[$urandom_range(0, 15)],
                 T4[$urandom_range(0, 15)], CTL[0], 0, 0, 0, 0, 0, 0);
        end else begin
            for (int i = 0; i < 2; i++)
                step(K_GB, T4[$urandom_range(0, 15)], GB, GB,
                     0, 0, 0, 0, 0, 0);
        end
        ctrl_cycles(3);
    endtask

    int         first;
    int         pulses;
    int         other;
    logic [9:0] rot;

    initial begin
        rst_n  = 1'b0;
        tmds_b = CTL[0];
        tmds_g = CTL[0];
        tmds_r = CTL[0];
        repeat (3) @(negedge pix_clk);
        check("rst_ctl", 64'({bitslip, aligned, vde, ade, err, hsync, vsync}),
              64'(0));
        check("rst_data", 64'({blue, green, red, aux0, aux1, aux2}), 64'(0));

        rot    = CTL[0];
        tmds_g = {rot[6:0], rot[9:7]};
        rst_n  = 1'b1;
        first  = -1;
        pulses = 0;
        other  = 0;
        for (int c = 1; c <= 4200; c++) begin
            @(negedge pix_clk);
            if (bitslip[1]) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (bitslip[0] || bitslip[2]) other++;
        end
        check("slip_pulses", 64'(pulses), 64'(1));
        check("slip_when", 64'(first >= 4090 && first <= 4110), 64'(1));
        check("slip_bg", 64'(other), 64'(0));
        check("slip_unaligned", 64'(aligned), 64'(0));

        rst_n  = 1'b0;
        tmds_g = CTL[0];
        @(negedge pix_clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge pix_clk);
            if (c == 10) check("align_early", 64'(aligned), 64'(0));
        end
        check("align_12", 64'(aligned), 64'(1));

        ctrl_cycles(4);
        step(K_CTRL, CTL[3], CTL[0], CTL[0], 0, 0, 0, 0, 0, 0);
        step(K_CTRL, CTL[0], CTL[0], CTL[0], 0, 0, 0, 0, 0, 0);

        preamble(PMIN, 1'b0);
        vguard();
        pixel(1'b1, 10'b0100000000, 8'h00);
        pixel(1'b1, 10'b1011111111, 8'hfe);
        pixel(1'b1, 10'b0111111111, 8'h01);
        step(K_CTRL, CTL[2], CTL[0], CTL[0], 0, 0, 0, 0, 0, 0);
        ctrl_cycles(2);

        for (int round = 0; round < 4; round++) begin
            preamble(PMIN + $urandom_range(0, 4), 1'b0);
            vguard();
            repeat ($urandom_range(5, 30)) pixel(1'b0, 10'd0, 8'd0);
            ctrl_cycles($urandom_range(1, 4));
            island($urandom_range(1, 12), 1'b0);
        end

        preamble(PMIN - 1, 1'b0);
        step(K_ERR, VGB, GB, VGB, 0, 0, 0, 0, 0, 0);
        ctrl_cycles(3);
        island(3, 1'b1);
        island(2, 1'b0);

        preamble(PMIN, 1'b0);
        vguard();
        repeat (4) pixel(1'b0, 10'd0, 8'd0);
        check("video_live", 64'(vde), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_vde", 64'(vde), 64'(0));
        check("rst_async_blue", 64'(blue), 64'(0));
        check("rst_async_align", 64'(aligned), 64'(0));
        @(negedge pix_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge pix_clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hdmi_rx_decode.md
HDMI_RX_DECODE -- requirements
Module: hdmi_rx_decode

Interface
REQ-001 Parameter MODE, default "HDMI", decoder mode "HDMI" or "DVI"; "DVI" disables preamble, guard-band and data-island decoding.
REQ-002 Parameter SEARCH_WINDOW, default 4096, cycles without a control token on a channel before that channel requests a bitslip.
REQ-003 Parameter PREAMBLE_MIN, default 8, consecutive identical preamble cycles that qualify a following guard band.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, and the ports SHALL be named pix_clk and rst_n.
REQ-005 pix_clk  in  1  pixel clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 tmds_b, tmds_g, tmds_r  in  10 each  parallel symbols from the deserializers, bit 0 first on the wire; inter-channel skew is removed upstream.
REQ-008 bitslip  out  3  one-cycle bitslip request per channel {r,g,b}.
REQ-009 aligned  out  1  all three channels word-locked.
REQ-010 blue, green, red  out  8 each  decoded video data.
REQ-011 hsync, vsync  out  1 each  decoded sync.
REQ-012 vde  out  1  video data enable.
REQ-013 aux0, aux1, aux2  out  4 each  TERC4 data from channels b, g, r.
REQ-014 ade  out  1  aux data enable.
REQ-015 err  out  1  one-cycle pulse on an illegal symbol or period sequence.

Function
REQ-016 Control tokens SHALL decode as follows: 1101010100=00, 0010101011=01, 0101010100=10 and 1010101011=11, giving {c1,c0}.
REQ-017 Video decode SHALL work as follows: b = din[9] ? ~din[7:0] : din[7:0]; d0 = b0; di = din[8] ? bi^bi-1 : ~(bi^bi-1).
REQ-018 TERC4 codes 0..15 SHALL be 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011 and 1011000011.
REQ-019 Per-channel alignment:
  - a counter SHALL clear on any control token and increment otherwise;
  - at SEARCH_WINDOW-1 it SHALL pulse bitslip, clear, and ignore the channel's symbols for 3 cycles;
  - the channel SHALL lock after 12 consecutive control tokens;
  - the channel SHALL unlock on a bitslip.
REQ-020 aligned SHALL be the AND of the three lock flags, registered.
REQ-021 The period FSM SHALL have states CTRL, VGB, VIDEO, DGB_L, ISLAND and DGB_T, and SHALL be held in CTRL while aligned=0.
REQ-022 In CTRL, a preamble counter SHALL count cycles while green {c1,c0}=01.
  - Red {c1,c0}=00 marks a video preamble; red {c1,c0}=01 marks an island preamble.
  - The counter SHALL clear when the preamble type changes.
REQ-023 CTRL->VGB SHALL occur when green=0100110011, the count is at least PREAMBLE_MIN and the type is video; CTRL->DGB_L SHALL occur on the same condition with type island.
REQ-024 VGB and DGB_L SHALL last exactly 2 cycles, then go to VIDEO and ISLAND respectively.
REQ-025 VIDEO SHALL hold while blue is not a control token; a control token SHALL move the FSM to CTRL.
REQ-026 ISLAND SHALL move to DGB_T when green and red both equal 0100110011; DGB_T SHALL last 2 cycles, then go to CTRL.
REQ-027 Illegal symbols SHALL pulse err and force the FSM to CTRL. Illegal means:
  - in ISLAND, a non-TERC4 symbol;
  - in CTRL, a non-control symbol that does not start a guard band.
REQ-028 In DVI mode, vde SHALL be 1 whenever aligned and blue is not a control token; ade SHALL be 0 always.
REQ-029 Output data rules:
  - {hsync,vsync} SHALL update from blue {c0,c1} in CTRL and from blue TERC4 bits [0],[1] in ISLAND, and SHALL hold otherwise;
  - red, green and blue SHALL be 0 when vde=0;
  - aux0..2 SHALL be 0 when ade=0.
REQ-030 All outputs SHALL be registered, with a fixed latency of 2 pix_clk cycles from input symbol to output; guard-band cycles SHALL produce vde=0 and ade=0.

Reset
REQ-031 While rst_n=0, all outputs SHALL be 0 immediately, the FSM SHALL be in CTRL, and all counters and lock flags SHALL be cleared.
REQ-032 Deassertion of rst_n SHALL be synchronised to pix_clk; the first decode is valid no earlier than 2 cycles after release.

Verification
REQ-033 Control tokens rotated by 3 bits on tmds_g SHALL produce a bitslip[1] pulse after 4096 cycles; with an unrotated stream on all channels, aligned=1 after 12 tokens.
REQ-034 After alignment, 8 cycles of video preamble, then 2 cycles of guard band, then blue 0100000000, 1011111111, 0111111111 SHALL give vde=1 and blue=0x00, 0xFE, 0x01 at 2-cycle latency; a blue token SHALL then drop vde.
REQ-035 An island preamble, then guard band, then green TERC4 1011001100 (code 8) SHALL give ade=1 and aux1=8, and red/green 0100110011 SHALL end the island.
REQ-036 Blue 1010101011 in CTRL SHALL give hsync=1 and vsync=1; a red non-TERC4 symbol in ISLAND SHALL pulse err and return the FSM to CTRL.
REQ-037 rst_n low mid-VIDEO SHALL force vde=0, blue=0x00 and aligned=0 asynchronously.
